// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES slices, one slice per stage.
// Optional signed-overflow output is built when PIPE_ADD_OVF_EN is defined.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef PIPE_ADD_OVF_EN
  ,output logic             out_ovf
`endif
);

   localparam int SLICE = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   // Register set r feeds stage r; set 0 holds the prepared operands captured at accept.
   logic [STAGES:0]  vld_q;
   logic [STAGES:0]  c_q;
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] s_q   [STAGES];
   logic [WIDTH-1:0] s_in  [STAGES];
   logic [WIDTH-1:0] s_nxt [STAGES];
   logic [STAGES-1:0] c_nxt;
   logic [SLICE:0]   slc;
   logic             stall;

   assign stall     = vld_q[STAGES] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = vld_q[STAGES];
   assign out_sum   = s_q[LAST];
   assign out_cout  = c_q[STAGES];

   always_comb begin
      slc     = '0;
      c_nxt   = '0;
      s_in[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         s_in[k] = s_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         slc = {1'b0, a_q[k][k*SLICE +: SLICE]} + {1'b0, b_q[k][k*SLICE +: SLICE]}
             + {{SLICE{1'b0}}, c_q[k]};
         s_nxt[k] = s_in[k];
         s_nxt[k][k*SLICE +: SLICE] = slc[SLICE-1:0];
         c_nxt[k] = slc[SLICE];
      end
   end

`ifdef PIPE_ADD_OVF_EN
   logic ovf_nxt;
   logic ovf_q;

   assign ovf_nxt = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                 && (s_nxt[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
   assign out_ovf = ovf_q;
`endif

   // Data registers only load behind a valid bit so outputs hold while out_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         c_q   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
`ifdef PIPE_ADD_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else if (!stall) begin
         vld_q <= {vld_q[STAGES-1:0], in_valid};
         if (in_valid) begin
            a_q[0] <= in_a;
            b_q[0] <= in_sub ? ~in_b : in_b;
            c_q[0] <= in_sub | in_cin;
         end
         for (int k = 0; k < STAGES; k++) begin
            if (vld_q[k]) begin
               s_q[k]   <= s_nxt[k];
               c_q[k+1] <= c_nxt[k];
            end
         end
         for (int k = 1; k < STAGES; k++) begin
            if (vld_q[k-1]) begin
               a_q[k] <= a_q[k-1];
               b_q[k] <= b_q[k-1];
            end
         end
`ifdef PIPE_ADD_OVF_EN
         if (vld_q[LAST]) ovf_q <= ovf_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4); checks out_ovf when PIPE_ADD_OVF_EN is defined.
module tb_pipelined_adder;
   localparam int W = 16;
   localparam int S = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_cin = 1'b0;
   logic          in_sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_sum;
   logic          out_cout;
`ifdef PIPE_ADD_OVF_EN
   logic          out_ovf;
`endif

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   n_out = 0;
   int   streak = 0;
   int   max_streak = 0;

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout)
`ifdef PIPE_ADD_OVF_EN
     ,.out_ovf(out_ovf)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [W-1:0] sum, input logic cout, input logic ovf);
      exp_t e;
      e.sum = sum; e.cout = cout; e.ovf = ovf;
      return e;
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      logic [W:0]   r;
      logic [W-1:0] be;
      be = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
      return mk(r[W-1:0], r[W], (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]));
   endfunction

   // Result monitor: pops the scoreboard on every output transfer.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid) streak++;
      else streak = 0;
      if (streak > max_streak) max_streak = streak;
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow: unexpected result sum=%h cout=%b", out_sum, out_cout);
         end else begin
            e = sb.pop_front();
            n_out++;
`ifdef PIPE_ADD_OVF_EN
            if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
               failures++;
               $display("FAIL result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                        out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
            end
`else
            if ({out_sum, out_cout} !== {e.sum, e.cout}) begin
               failures++;
               $display("FAIL result: got sum=%h cout=%b, want sum=%h cout=%b",
                        out_sum, out_cout, e.sum, e.cout);
            end
`endif
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input exp_t e);
      bit ok = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL send_timeout: in_ready stayed 0, want 1");
      end else begin
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200; t++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      @(posedge clk); #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d results outstanding, want 0", sb.size());
      end
   endtask

   task automatic check_latency(input string name);
      bit early = 0;
      for (int i = 1; i <= S; i++) begin
         @(posedge clk); #1;
         if (i < S && out_valid) early = 1;
      end
      checks++;
      if (early || !out_valid) begin
         failures++;
         $display("FAIL %s: early=%b out_valid at edge+%0d=%b, want early=0 valid=1",
                  name, early, S, out_valid);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({out_valid, in_ready, out_sum, out_cout} !== {1'b0, 1'b1, 16'h0000, 1'b0}) begin
         failures++;
         $display("FAIL reset_state: valid=%b ready=%b sum=%h cout=%b, want 0 1 0000 0",
                  out_valid, in_ready, out_sum, out_cout);
      end
`ifdef PIPE_ADD_OVF_EN
      checks++;
      if (out_ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_ovf: got %b want 0", out_ovf);
      end
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_directed();
      send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0));
      check_latency("latency_first");
      drain();
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
      send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
      send(16'h0007, 16'h0005, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0));
`ifdef PIPE_ADD_OVF_EN
      send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
`endif
      send(16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0));
      drain();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_sum, out_cout} !== {1'b0, 16'h5556, 1'b0}) begin
         failures++;
         $display("FAIL idle_hold: valid=%b sum=%h cout=%b, want 0 5556 0",
                  out_valid, out_sum, out_cout);
      end
   endtask

   task automatic test_back_to_back();
      int n0 = n_out;
      max_streak = 0;
      for (int i = 0; i < 8; i++) begin
         send(16'(i), 16'(i * 16'h1111), 1'b0, 1'b0, model(16'(i), 16'(i * 16'h1111), 1'b0, 1'b0));
      end
      drain();
      checks++;
      if (max_streak != 8 || n_out - n0 != 8) begin
         failures++;
         $display("FAIL back_to_back: streak=%0d results=%0d, want 8 8", max_streak, n_out - n0);
      end
   endtask

   task automatic test_backpressure();
      int n0 = n_out;
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               logic [W-1:0] a = 16'(i * 16'h0F0F + 16'h00F1);
               logic [W-1:0] b = 16'(16'hF00F - i);
               send(a, b, i[0], i[1], model(a, b, i[0], i[1]));
            end
         end
         begin
            logic [W-1:0] snap_sum;
            logic         snap_cout;
            bit           seen = 0;
            for (int t = 0; t < 50; t++) begin
               @(negedge clk);
               if (out_valid) begin seen = 1; break; end
            end
            checks++;
            if (!seen) begin
               failures++;
               $display("FAIL bp_first: out_valid never rose, want 1");
            end
            @(posedge clk); #1;
            snap_sum = out_sum; snap_cout = out_cout;
            out_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               checks++;
               if ({out_valid, in_ready, out_sum, out_cout} !== {1'b1, 1'b0, snap_sum, snap_cout}) begin
                  failures++;
                  $display("FAIL bp_hold%0d: valid=%b ready=%b sum=%h cout=%b, want 1 0 %h %b",
                           j, out_valid, in_ready, out_sum, out_cout, snap_sum, snap_cout);
               end
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      checks++;
      if (n_out - n0 != 6) begin
         failures++;
         $display("FAIL bp_count: results=%0d, want 6", n_out - n0);
      end
   endtask

   task automatic test_random();
      fork
         begin
            for (int n = 0; n < 20; n++) begin
               logic [W-1:0] a = 16'($urandom);
               logic [W-1:0] b = 16'($urandom);
               logic         c = 1'($urandom_range(0, 1));
               logic         s = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
               send(a, b, c, s, model(a, b, c, s));
            end
         end
         begin
            repeat (60) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();
   endtask

   task automatic test_reset_mid();
      bit stale = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(16'(16'h0101 * (i + 1)), 16'h0010, 1'b0, 1'b0,
              model(16'(16'h0101 * (i + 1)), 16'h0010, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre: out_valid=%b, want 1", out_valid);
      end
      rst_n = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failures++;
         $display("FAIL rst_mid: valid=%b ready=%b, want 0 1", out_valid, in_ready);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) stale = 1;
      end
      checks++;
      if (stale) begin
         failures++;
         $display("FAIL rst_stale: out_valid seen after reset, want none");
      end
      @(posedge clk); #1;
      send(16'hABCD, 16'h1111, 1'b1, 1'b0, mk(16'hBCDF, 1'b0, 1'b0));
      check_latency("latency_after_reset");
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes. A WIDTH-bit operation is split into STAGES equal slices, one slice per pipeline stage, with the slice carry registered between stages. It sustains one operation per cycle with a fixed latency of STAGES cycles. It is the shared arithmetic primitive for datapaths wider than the 4-bit combinational adder, sitting between operand registers and downstream accumulation logic.

## Interface
- WIDTH, default 16: operand and sum width. Must be ≥ 2.
- STAGES, default 4: number of pipeline stages. WIDTH % STAGES == 0; SLICE = WIDTH/STAGES.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A, unsigned or two's complement.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in; ignored when in_sub=1.
- in_sub  input  1  0: A+B+cin; 1: A−B, computed as A+~B+1.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- out_ovf  output  1  signed overflow. Present only with PIPE_ADD_OVF_EN.

## Operation
- Accept: an input beat transfers on a rising edge where in_valid && in_ready.
- Operand preparation happens at accept:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? 1 : in_cin.
- Stage k (0..STAGES−1) adds slice k of A and b_eff plus the carry registered by stage k−1 (c0 for stage 0). It registers the SLICE sum bits and the carry out.
- Operand slices not yet consumed travel with the beat in skew registers. Sum slices already produced are carried forward alongside them.
- A per-stage valid bit travels with each beat. Invalid stages (bubbles) propagate without changing results.
- out_valid, out_sum, out_cout (and out_ovf) are the final stage's registers.
- Stall: stall = out_valid && !out_ready. During a stall, every stage register holds its value and in_ready = 0.
- in_ready = !stall. The path from out_ready to in_ready is combinational.
- Bubbles are not collapsed during a stall; the whole pipe freezes as one unit.
- Result transfer: the result leaves on an edge where out_valid && out_ready. If no new beat reaches the final stage on that edge, out_valid drops.
- Width rules:
  - out_sum = (A + b_eff + c0) mod 2^WIDTH.
  - out_cout = bit WIDTH of the (WIDTH+1)-bit sum.
  - No saturation.

## Timing
- Reset (rst_n low, asynchronous assertion): all valid bits, out_valid, out_sum, out_cout and out_ovf are 0.
- in_ready is 1 whenever out_valid is 0, including during reset.
- On rst_n deassertion, beats may be accepted on the first rising edge.
- Latency: a beat accepted at edge t presents out_valid=1 after edge t+STAGES, provided no stall occurs in between.
- Throughput: 1 beat/cycle with out_ready held high. Results emerge in acceptance order.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- Simultaneous accept and output transfer in the same cycle are legal. Both complete.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Data outputs are don't-care-stable while out_valid=0: they hold their last value and are not cleared.

## Configuration
- PIPE_ADD_OVF_EN defined:
  - The out_ovf port exists.
  - out_ovf = (A[MSB] == b_eff[MSB]) && (out_sum[MSB] != A[MSB]).
  - It is registered alongside the final stage, resets to 0, and holds during a stall.
- PIPE_ADD_OVF_EN undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1. Accept A=0x00FF, B=0x0001, cin=0 → 4 cycles later out_sum=0x0100, out_cout=0. This checks carry across a slice boundary.
- Accept A=0xFFFF, B=0x0000, cin=1 → out_sum=0x0000, out_cout=1. This checks the carry rippling through all stages.
- Subtract: A=0x0005, B=0x0007, sub=1 → out_sum=0xFFFE, out_cout=0. A=0x0007, B=0x0005, sub=1 → out_sum=0x0002, out_cout=1. With PIPE_ADD_OVF_EN, A=0x8000, B=0x0001, sub=1 → out_ovf=1.
- Back-to-back stream: 8 beats, in_valid held high, A=i, B=i·0x1111 → 8 consecutive out_valid cycles, in order, correct sums.
- Backpressure: after the first result appears, drop out_ready for 3 cycles → in_ready=0 and outputs hold for those 3 cycles. On release, the remaining results are delivered in order with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0 immediately. After release, no stale beat appears and a fresh beat returns after 4 cycles.
